// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the memory dump reader.
//   state_t     : controller state encoding (IDLE, FETCH, SEND, DONE)
//   WORD_BYTES  : byte stride between consecutive dumped words
//   word_align  : clears the byte-offset bits of an address
package mem_dump_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Memory dump reader: walks word_count consecutive 32-bit words of data
// memory starting at base_adr and streams them out as valid/ready beats.
// Shares the data-memory read port with the CPU; the port address is only
// driven (non-zero) while a word is being fetched.
//
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   start, abort    : begin a dump (idle only) / terminate a dump in flight
//   base_adr        : byte start address (low two bits ignored)
//   word_count      : number of words to dump (0 = complete immediately)
//   Rd_DataAdr      : read address to data memory
//   Rd_ReadData     : combinational read data for Rd_DataAdr
//   out_valid/out_ready/out_data/out_adr/out_last : output beat stream
//   busy            : high whenever the controller is not idle
//   done            : one-cycle pulse after a dump completes normally
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] word_count,
  output logic [31:0]      Rd_DataAdr,
  input  logic [31:0]      Rd_ReadData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [31:0]      out_adr,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [31:0]      adr;
  logic [CNT_W-1:0] remaining;

  // The read port is shared with the CPU, so keep it at zero unless fetching.
  assign Rd_DataAdr = (state == FETCH) ? adr : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      adr       <= 32'h0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_adr   <= 32'h0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (word_count != '0) begin
              adr       <= word_align(base_adr);
              remaining <= word_count;
              state     <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end

        FETCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            out_data  <= Rd_ReadData;
            out_adr   <= adr;
            out_last  <= (remaining == CNT_W'(1));
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end

        SEND: begin
          // Abort wins over a handshake in the same cycle.
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
            end else begin
              adr       <= adr + WORD_BYTES;  // wraps modulo 2^32
              remaining <= remaining - CNT_W'(1);
              state     <= FETCH;
            end
          end
        end

        DONE: begin
          // done is registered, so it is visible in the first idle cycle.
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Self-checking bench for mem_dump_reader: a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized stress phase.
module tb_mem_dump_reader;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      base_adr = 32'h0;
  logic [CNT_W-1:0] word_count = '0;
  logic [31:0]      Rd_DataAdr;
  logic [31:0]      Rd_ReadData;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic [31:0]      out_adr;
  logic             out_last;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  // accepted beats, as seen on the DUT outputs
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  bit          log_last[$];

  always #5 clk = ~clk;

  mem_dump_reader #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .base_adr   (base_adr),
    .word_count (word_count),
    .Rd_DataAdr (Rd_DataAdr),
    .Rd_ReadData(Rd_ReadData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_adr    (out_adr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // data memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hA;
      32'h14:  return 32'hB;
      32'h18:  return 32'hC;
      default: return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endcase
  endfunction

  assign Rd_ReadData = mem_word(Rd_DataAdr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // m_busy : a dump with beats is in progress
  // wait_n : cycles still spent fetching before the head beat is offered
  // done_n : 2 = in completion cycle, 1 = done pulse due this cycle
  bit          m_busy = 1'b0;
  int          wait_n = 0;
  int          done_n = 0;
  logic [31:0] q[$];

  initial begin
    bit e_valid, e_fetch, e_busy, e_done;
    logic [31:0] a0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 1'b0;
        wait_n = 0;
        done_n = 0;
        q.delete();
      end else begin
        e_valid = m_busy && (wait_n == 0);
        e_fetch = m_busy && (wait_n != 0);
        e_busy  = m_busy || (done_n == 2);
        e_done  = (done_n == 1);
        chk_b("mdl_valid", out_valid, e_valid);
        chk_b("mdl_busy", busy, e_busy);
        chk_b("mdl_done", done, e_done);
        chk("mdl_rd_adr", Rd_DataAdr, e_fetch ? q[0] : 32'h0);
        if (e_valid) begin
          chk("mdl_adr", out_adr, q[0]);
          chk("mdl_data", out_data, mem_word(q[0]));
          chk_b("mdl_last", out_last, q.size() == 1);
        end
        if (done_n > 0) done_n--;
        if (wait_n > 0) wait_n--;
        if (!e_busy) begin
          if (start) begin
            if (word_count == '0) begin
              done_n = 2;
            end else begin
              m_busy = 1'b1;
              wait_n = 1;
              a0 = {base_adr[31:2], 2'b00};
              for (int i = 0; i < int'(word_count); i++) q.push_back(a0 + 32'(4 * i));
            end
          end
        end else if (m_busy && abort) begin
          m_busy = 1'b0;
          wait_n = 0;
          q.delete();
        end else if (e_valid && out_ready) begin
          log_adr.push_back(out_adr);
          log_dat.push_back(out_data);
          log_last.push_back(out_last);
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_busy = 1'b0;
            done_n = 2;
          end else begin
            wait_n = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] n);
    start      = 1'b1;
    base_adr   = b;
    word_count = n;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done) && n < 400) begin
      step(1);
      n++;
    end
    chk_b(name, busy, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      step(1);
      n++;
    end
    chk_b(name, out_valid, 1'b1);
  endtask

  task automatic clear_log();
    log_adr.delete();
    log_dat.delete();
    log_last.delete();
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    int n;

    // reset state
    step(2);
    chk_b("rst_valid", out_valid, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk("rst_rdadr", Rd_DataAdr, 32'h0);
    chk("rst_data", out_data, 32'h0);
    reset = 1'b1;
    step(1);

    // three-word dump with a ready consumer
    clear_log();
    do_start(32'h10, 3);
    chk_b("t1_valid_early", out_valid, 1'b0);
    step(1);
    chk_b("t1_valid_rise", out_valid, 1'b1);
    wait_idle("t1_idle");
    chk("t1_nbeats", log_adr.size(), 3);
    if (log_adr.size() == 3) begin
      chk("t1_a0", log_adr[0], 32'h10); chk("t1_d0", log_dat[0], 32'hA); chk_b("t1_l0", log_last[0], 1'b0);
      chk("t1_a1", log_adr[1], 32'h14); chk("t1_d1", log_dat[1], 32'hB); chk_b("t1_l1", log_last[1], 1'b0);
      chk("t1_a2", log_adr[2], 32'h18); chk("t1_d2", log_dat[2], 32'hC); chk_b("t1_l2", log_last[2], 1'b1);
    end

    // zero-length dump
    clear_log();
    do_start(32'h40, 0);
    chk_b("t2_busy", busy, 1'b1);
    chk_b("t2_done_early", done, 1'b0);
    step(1);
    chk_b("t2_done", done, 1'b1);
    chk_b("t2_valid", out_valid, 1'b0);
    step(1);
    chk_b("t2_done_off", done, 1'b0);
    chk("t2_nbeats", log_adr.size(), 0);

    // back-pressure on the first beat
    clear_log();
    out_ready = 1'b0;
    do_start(32'h100, 3);
    wait_valid("t3_valid");
    begin
      logic [31:0] d0, a0;
      d0 = out_data;
      a0 = out_adr;
      chk("t3_a_first", a0, 32'h100);
      for (int i = 0; i < 5; i++) begin
        step(1);
        chk_b("t3_hold_valid", out_valid, 1'b1);
        chk("t3_hold_data", out_data, d0);
        chk("t3_hold_adr", out_adr, a0);
      end
    end
    out_ready = 1'b1;
    wait_idle("t3_idle");
    chk("t3_nbeats", log_adr.size(), 3);
    if (log_adr.size() == 3) begin
      chk("t3_a0", log_adr[0], 32'h100); chk("t3_d0", log_dat[0], mem_word(32'h100));
      chk("t3_a1", log_adr[1], 32'h104); chk("t3_d1", log_dat[1], mem_word(32'h104));
      chk("t3_a2", log_adr[2], 32'h108); chk_b("t3_l2", log_last[2], 1'b1);
    end

    // unaligned base near the top of the address space
    clear_log();
    do_start(32'hFFFF_FFFB, 2);
    wait_idle("t4_idle");
    chk("t4_nbeats", log_adr.size(), 2);
    if (log_adr.size() == 2) begin
      chk("t4_a0", log_adr[0], 32'hFFFF_FFF8); chk_b("t4_l0", log_last[0], 1'b0);
      chk("t4_a1", log_adr[1], 32'hFFFF_FFFC); chk_b("t4_l1", log_last[1], 1'b1);
    end

    // abort on beat 2 of 4, colliding with a handshake
    clear_log();
    do_start(32'h200, 4);
    n = 0;
    while (log_adr.size() < 1 && n < 50) begin step(1); n++; end
    chk("t5_first_beat", log_adr.size(), 1);
    wait_valid("t5_beat2");
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk_b("t5_valid_off", out_valid, 1'b0);
    chk_b("t5_busy_off", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_b("t5_no_done", done, 1'b0);
      step(1);
    end
    chk("t5_nbeats", log_adr.size(), 1);
    do_start(32'h300, 2);
    wait_idle("t5_restart_idle");
    chk("t5_nbeats2", log_adr.size(), 3);
    if (log_adr.size() == 3) begin
      chk("t5_ra0", log_adr[1], 32'h300);
      chk("t5_ra1", log_adr[2], 32'h304);
      chk_b("t5_rl1", log_last[2], 1'b1);
    end

    // asynchronous reset mid-dump
    do_start(32'h400, 4);
    wait_valid("t6_valid");
    #2;
    reset = 1'b0;
    #1;
    chk_b("t6_valid", out_valid, 1'b0);
    chk_b("t6_last", out_last, 1'b0);
    chk_b("t6_busy", busy, 1'b0);
    chk_b("t6_done", done, 1'b0);
    chk("t6_data", out_data, 32'h0);
    chk("t6_adr", out_adr, 32'h0);
    chk("t6_rdadr", Rd_DataAdr, 32'h0);
    start = 1'b1;
    step(2);
    chk_b("t6_start_ign", busy, 1'b0);
    start = 1'b0;
    reset = 1'b1;
    step(3);
    chk_b("t6_post_busy", busy, 1'b0);
    chk_b("t6_post_valid", out_valid, 1'b0);

    // randomized traffic; the model process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      word_count = CNT_W'($urandom_range(0, 5));
      base_adr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
      step(1);
    end
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    wait_idle("rnd_drain");
    step(3);
    chk_b("rnd_final_valid", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of word_count.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminate the dump in progress.
REQ-006 SHALL have port base_adr  input  32  byte start address; bits [1:0] ignored.
REQ-007 SHALL have port word_count  input  CNT_W  number of 32-bit words to dump.
REQ-008 SHALL have port Rd_DataAdr  output  32  address driven to the data-memory read port.
REQ-009 SHALL have port Rd_ReadData  input  32  combinational read data for Rd_DataAdr.
REQ-010 SHALL have port out_valid  output  1  out_data/out_adr/out_last valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the current beat.
REQ-012 SHALL have port out_data  output  32  dumped word.
REQ-013 SHALL have port out_adr  output  32  byte address of out_data.
REQ-014 SHALL have port out_last  output  1  marks the final beat.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at normal completion.

Function
REQ-017 SHALL implement states IDLE, FETCH, SEND, DONE.
REQ-018 IDLE, start=1, word_count!=0: SHALL latch {base_adr[31:2],2'b00} and word_count, and go to FETCH.
REQ-019 IDLE, start=1, word_count=0: SHALL go to DONE with no beats issued.
REQ-020 In FETCH, SHALL drive Rd_DataAdr = current address, capture Rd_ReadData into out_data and the address into out_adr, and go to SEND after exactly one cycle.
REQ-021 In SEND, SHALL hold out_valid=1 with stable out_data, out_adr and out_last until out_valid & out_ready.
REQ-022 SHALL set out_last=1 only on the beat whose remaining count is 1.
REQ-023 On handshake of a non-last beat, SHALL add 4 to the address, decrement the remaining count, and go to FETCH.
REQ-024 On handshake of the last beat, SHALL go to DONE.
REQ-025 Throughput SHALL be at most one beat per 2 cycles; out_valid SHALL rise 2 cycles after start is accepted.
REQ-026 In DONE, SHALL assert done for exactly one cycle, then go to IDLE.
REQ-027 Address increment SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0x00000000) with no error.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort in FETCH or SEND SHALL go to IDLE on the next edge, drop out_valid, and suppress done; abort has priority over a same-cycle handshake.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 Rd_DataAdr SHALL be 0 in every state other than FETCH.
REQ-032 Remaining count SHALL be CNT_W bits; word_count = 2^CNT_W-1 SHALL dump the full count.

Reset
REQ-033 While reset=0, SHALL force state=IDLE, out_valid=0, out_last=0, busy=0, done=0, out_data=0, out_adr=0, Rd_DataAdr=0, and internal address and count to 0, independent of clk.
REQ-034 Reset asserted mid-dump SHALL discard the dump; after release, the block SHALL wait in IDLE for a new start.

Structure
REQ-035 A shared package SHALL hold the state encoding typedef (IDLE, FETCH, SEND, DONE) and the constant WORD_BYTES=4.
REQ-036 SHALL be a single module with no sub-modules; it connects to the data_mem read port alongside the CPU.

Verification
REQ-037 SHALL verify: base_adr=0x10, word_count=3, memory 0x10/0x14/0x18 = 0xA, 0xB, 0xC, out_ready=1 -> beats (0x10,0xA), (0x14,0xB), (0x18,0xC,last), then a done pulse.
REQ-038 SHALL verify: word_count=0 -> no out_valid; done pulses 2 cycles after start.
REQ-039 SHALL verify: out_ready held 0 for 5 cycles on beat 1 -> out_valid, out_data and out_adr stable across all 5 cycles, with no skipped or repeated beat.
REQ-040 SHALL verify: base_adr=0xFFFFFFFB, word_count=2 -> out_adr 0xFFFFFFF8, then 0xFFFFFFFC.
REQ-041 SHALL verify: abort during beat 2 of 4 -> out_valid=0 next cycle, no done, busy=0, and a following start runs normally.
REQ-042 SHALL verify: reset driven low between clock edges mid-dump -> all outputs at reset values immediately; start is ignored while reset=0.
